// File: rtl/memory_stage_if.sv
// Bundle of the execute-side, data-RAM and writeback signals of the memory stage.
// The slave modport is the stage's view. The master modport is the view of the surrounding pipeline and RAM.
interface memory_stage_if;
  logic        exe_valid;
  logic        exe_ready;
  logic        exe_wen;
  logic [4:0]  exe_regsrc;
  logic [31:0] exe_alu_result;
  logic        exe_is_load;
  logic        exe_is_store;
  logic [2:0]  exe_ld_type;
  logic [1:0]  exe_st_type;
  logic [31:0] exe_st_data;

  logic        dram_req;
  logic [3:0]  dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;

  logic        mem_valid;
  logic        mem_wen;
  logic [4:0]  mem_regsrc;
  logic [31:0] mem_result;
  logic        mem_exc;

  modport slave (
    input  exe_valid, exe_wen, exe_regsrc, exe_alu_result, exe_is_load,
           exe_is_store, exe_ld_type, exe_st_type, exe_st_data,
           dram_ack, dram_rdata,
    output exe_ready, dram_req, dram_we, dram_addr, dram_wdata,
           mem_valid, mem_wen, mem_regsrc, mem_result, mem_exc
  );

  modport master (
    output exe_valid, exe_wen, exe_regsrc, exe_alu_result, exe_is_load,
           exe_is_store, exe_ld_type, exe_st_type, exe_st_data,
           dram_ack, dram_rdata,
    input  exe_ready, dram_req, dram_we, dram_addr, dram_wdata,
           mem_valid, mem_wen, mem_regsrc, mem_result, mem_exc
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage CPU: registers the execute result and runs data-RAM loads and stores over req/ack.
// It also aligns and extends load data into one merged writeback result.
module memory_stage (
  input  logic           clk,
  input  logic           reset,
  memory_stage_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b01;
  localparam logic [1:0] ST_SH  = 2'b10;

  state_t      r_state;
  logic [31:0] r_addr;
  logic        r_is_load;
  logic [2:0]  r_ld_type;
  logic [4:0]  r_regsrc;
  logic        r_wen;
  logic        r_dram_req;
  logic [3:0]  r_dram_we;
  logic [31:0] r_dram_wdata;
  logic        r_mem_valid;
  logic        r_mem_wen;
  logic        r_mem_exc;
  logic [4:0]  r_mem_regsrc;
  logic [31:0] r_mem_result;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misaligned;
  logic [3:0]  w_st_we;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_accept = bus.exe_valid && (r_state == IDLE);
  assign w_is_mem = bus.exe_is_load || bus.exe_is_store;

  // A set exe_is_load wins over exe_is_store. Unused load codes check alignment as lw.
  // NOTE: every signal driven in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_misaligned = 1'b0;
    if (bus.exe_is_load) begin
      case (bus.exe_ld_type)
        LD_LB, LD_LBU: w_misaligned = 1'b0;
        LD_LH, LD_LHU: w_misaligned = bus.exe_alu_result[0];
        default:       w_misaligned = |bus.exe_alu_result[1:0];
      endcase
    end else if (bus.exe_is_store) begin
      case (bus.exe_st_type)
        ST_SB:   w_misaligned = 1'b0;
        ST_SH:   w_misaligned = bus.exe_alu_result[0];
        default: w_misaligned = |bus.exe_alu_result[1:0];
      endcase
    end
  end

  always_comb begin
    w_st_we    = 4'b1111;
    w_st_wdata = bus.exe_st_data;
    case (bus.exe_st_type)
      ST_SB: begin
        w_st_we    = 4'b0001 << bus.exe_alu_result[1:0];
        w_st_wdata = {4{bus.exe_st_data[7:0]}};
      end
      ST_SH: begin
        w_st_we    = bus.exe_alu_result[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{bus.exe_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = bus.dram_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? bus.dram_rdata[31:16] : bus.dram_rdata[15:0];

  always_comb begin
    w_load_data = bus.dram_rdata;
    case (r_ld_type)
      LD_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_load_data = {24'b0, w_byte};
      LD_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_load_data = {16'b0, w_half};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  // NOTE: the latched instruction fields are not reset. They are only read in ACCESS, which is always entered through an accept that loads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_dram_req   <= 1'b0;
      r_dram_we    <= 4'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_exc    <= 1'b0;
      r_mem_regsrc <= 5'b0;
      r_mem_result <= 32'b0;
    end else begin
      r_mem_valid <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_exc   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_mem_valid  <= 1'b1;
              r_mem_wen    <= bus.exe_wen;
              r_mem_regsrc <= bus.exe_regsrc;
              r_mem_result <= bus.exe_alu_result;
            end else if (w_misaligned) begin
              r_mem_valid  <= 1'b1;
              r_mem_exc    <= 1'b1;
              r_mem_regsrc <= bus.exe_regsrc;
              r_mem_result <= bus.exe_alu_result;
            end else begin
              r_addr       <= bus.exe_alu_result;
              r_is_load    <= bus.exe_is_load;
              r_ld_type    <= bus.exe_ld_type;
              r_regsrc     <= bus.exe_regsrc;
              r_wen        <= bus.exe_wen;
              r_dram_req   <= 1'b1;
              r_dram_we    <= bus.exe_is_load ? 4'b0000 : w_st_we;
              r_dram_wdata <= w_st_wdata;
              r_state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus.dram_ack) begin
            r_dram_req   <= 1'b0;
            r_dram_we    <= 4'b0;
            r_mem_valid  <= 1'b1;
            r_mem_wen    <= r_is_load && r_wen;
            r_mem_regsrc <= r_regsrc;
            r_mem_result <= r_is_load ? w_load_data : r_addr;
            r_state      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.exe_ready  = (r_state == IDLE);
  assign bus.dram_req   = r_dram_req;
  assign bus.dram_we    = r_dram_we;
  assign bus.dram_addr  = {r_addr[31:2], 2'b00};
  assign bus.dram_wdata = r_dram_wdata;
  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_exc    = r_mem_exc;
  assign bus.mem_regsrc = r_mem_regsrc;
  assign bus.mem_result = r_mem_result;
endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 5-stage CPU, between the execute stage and writeback. It registers the execute-stage result and performs data-RAM loads and stores over a req/ack handshake. It aligns and sign- or zero-extends load data and presents a single merged result to writeback. Writeback then needs no load select. The execute stage is back-pressured for as long as a memory access is outstanding.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- exe_valid  in  1  execute stage presents an instruction
- exe_ready  out  1  stage can accept this cycle
- exe_wen  in  1  instruction writes a register
- exe_regsrc  in  5  destination register
- exe_alu_result  in  32  ALU result; byte address for loads and stores
- exe_is_load  in  1  load instruction
- exe_is_store  in  1  store instruction
- exe_ld_type  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
- exe_st_type  in  2  00 sw, 01 sb, 10 sh
- exe_st_data  in  32  store data (rt)
- dram_req  out  1  memory request; held until ack
- dram_we  out  4  byte write enables; 0000 = read
- dram_addr  out  32  word address {addr[31:2],2'b00}
- dram_wdata  out  32  aligned store data
- dram_ack  in  1  request complete; read data valid this cycle
- dram_rdata  in  32  read word
- mem_valid  out  1  one-cycle pulse per retired instruction
- mem_wen  out  1  register write enable to writeback
- mem_regsrc  out  5  destination register
- mem_result  out  32  final write data (aligned load or ALU result)
- mem_exc  out  1  misaligned-access pulse, coincident with mem_valid

## Operation
States: IDLE and ACCESS.
- **exe_ready** is 1 in IDLE and 0 in ACCESS. Accept = exe_valid & exe_ready.
- **IDLE, accept of a non-memory instruction:** on the next cycle mem_valid=1, mem_wen=exe_wen, mem_result=exe_alu_result. State stays IDLE.
- **IDLE, accept of an aligned load or store:**
  - Latch address, type, regsrc, wen and store data; go to ACCESS.
  - dram_req=1 from the next cycle.
- **Misaligned access:** lw/sw with addr[1:0]≠00, or lh/lhu/sh with addr[0]=1.
  - No request is issued; state stays IDLE.
  - Next cycle: mem_valid=1, mem_exc=1, mem_wen=0.
- **ACCESS:** dram_req, dram_we, dram_addr and dram_wdata are held stable until the cycle dram_ack=1. On that edge the stage returns to IDLE, and on the following cycle:
  - mem_valid=1, dram_req=0.
  - mem_result = extracted load data for loads.
  - mem_wen = 0 for stores, otherwise the latched wen.
- **Store enables and data:**
  - sw: we=1111, wdata=st_data.
  - sb: we=0001<<addr[1:0], wdata={4{st_data[7:0]}}.
  - sh: we = addr[1] ? 1100 : 0011, wdata={2{st_data[15:0]}}.
- **Load extraction:**
  - Byte b = rdata[8*addr[1:0]+:8]; lb sign-extends it, lbu zero-extends it.
  - Half h = rdata[16*addr[1]+:16]; lh sign-extends it, lhu zero-extends it.
  - lw passes rdata unchanged.
- **Invalid inputs:**
  - Unused ld_type codes (101–111) behave as lw.
  - exe_is_load and exe_is_store both set: treat as load.
- **Reset:**
  - State→IDLE.
  - dram_req, dram_we, mem_valid, mem_wen, mem_exc, mem_regsrc and mem_result all go to 0.
  - An outstanding request is abandoned. Memory must drop it on reset, and an ack arriving in the reset cycle is ignored.

## Timing
- Non-memory instruction: accepted at edge N, mem_valid high during cycle N+1. Throughput 1 per cycle.
- Memory instruction: accepted at edge N.
  - dram_req high in cycles N+1 … A, where A is the first cycle with dram_ack=1.
  - mem_valid high in cycle A+1. exe_ready low in cycles N+1 … A.
- dram_ack=1 coinciding with the request's first cycle: 1-cycle memory, load-to-use result at N+2.
- dram_ack while not in ACCESS: ignored.
- mem_valid, mem_exc and mem_wen are deasserted in any cycle with no retirement; mem_wen is never high without mem_valid.
- The IDLE accept in the cycle A+1 result is visible is allowed, giving back-to-back operation.

## Test plan
- **ALU stream:** 3 consecutive non-memory instructions, wen=1, regsrc 5/6/7, results 0x11/0x22/0x33 → mem_valid on 3 consecutive cycles with matching regsrc and result; exe_ready stays 1.
- **lb with wait states:** address 0x1003, ack after 3 request cycles, rdata 0x80FF_1234 → dram_addr 0x1000 and req held 3 cycles, exe_ready low; then mem_result 0xFFFF_FF80, mem_wen=1. Same case with lbu → 0x0000_0080.
- **sh:** address 0x2002, st_data 0xABCD_BEEF, ack after 1 cycle → dram_we 1100, wdata 0xBEEF_BEEF; then mem_valid=1, mem_wen=0.
- **Misaligned lw:** address 0x3001 → no dram_req; next cycle mem_valid=1, mem_exc=1, mem_wen=0.
- **Reset in ACCESS:** reset asserted while a load's req is pending, with ack in the same cycle → next cycle req=0, state IDLE, mem_valid=0; the following instruction is accepted normally.
- **lhu then immediate lw:** lhu at 0x4002, rdata 0x9876_5432, 1-cycle ack → 0x0000_9876. An lw at 0x4004 presented continuously is accepted in the cycle after ack.
